// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller.
// Anti-ghost blanking, brightness PWM, blink and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int NDIG      = 8,
  parameter int BLANK_CYC = 4,
  parameter int PWM_W     = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tick,
  input  logic [4*NDIG-1:0]     data,
  input  logic [PWM_W-1:0]      bright,
  input  logic [NDIG-1:0]       blink_mask,
  input  logic                  blink_phase,
  input  logic                  lz_en,
  output logic [NDIG-1:0]       an,
  output logic [3:0]            digit_val,
  output logic [$clog2(NDIG)-1:0] scan_idx,
  output logic                  blank
);

  localparam int IW = $clog2(NDIG);
  localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYC - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t          state_q, state_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [3:0]      dval_q, dval_d;

  logic [NDIG-1:0] tail_zero;
  logic            supp;
  logic            lit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_BLANK;
      bcnt_q  <= BLANK_INIT;
      pwm_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      dval_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pwm_q   <= pwm_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      dval_q  <= dval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    pwm_d   = pwm_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_BLANK: begin
        if (bcnt_q == 4'd0) state_d = S_ON;
        else                bcnt_d  = bcnt_q - 1'b1;
      end
      S_ON: begin
        if (tick) begin
          idx_d   = idx_q + 1'b1;
          pwm_d   = '0;
          bcnt_d  = BLANK_INIT;
          state_d = S_BLANK;
        end else begin
          pwm_d   = pwm_q + 1'b1;
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // tail_zero[i]: every digit from i up to the top is zero
  always_comb begin
    tail_zero = '0;
    tail_zero[NDIG-1] = (data[4*(NDIG-1) +: 4] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      tail_zero[i] = tail_zero[i+1] & (data[4*i +: 4] == 4'd0);
    end
  end

  // Anode is computed against the next-cycle state so it lands aligned
  always_comb begin
    supp   = lz_en && (idx_d != '0) && tail_zero[idx_d];
    lit    = (pwm_d <= bright)
           && !(blink_mask[idx_d] && blink_phase)
           && !supp;
    an_d   = '1;
    if (state_d == S_ON && lit) an_d[idx_d] = 1'b0;
    dval_d = data[{idx_q, 2'b00} +: 4];
  end

  assign an        = an_q;
  assign digit_val = dval_q;
  assign scan_idx  = idx_q;
  assign blank     = (state_q == S_BLANK);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl.
// Reference model tracks slot age; monitor compares every cycle.
module tb_seg_scan_ctrl;

  localparam int BLANK_CYC = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tick;
  logic [31:0] data;
  logic [2:0]  bright;
  logic [7:0]  blink_mask;
  logic        blink_phase;
  logic        lz_en;
  logic [7:0]  an;
  logic [3:0]  digit_val;
  logic [2:0]  scan_idx;
  logic        blank;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(8), .BLANK_CYC(BLANK_CYC), .PWM_W(3)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .data(data),
    .bright(bright), .blink_mask(blink_mask),
    .blink_phase(blink_phase), .lz_en(lz_en),
    .an(an), .digit_val(digit_val),
    .scan_idx(scan_idx), .blank(blank)
  );

  typedef struct {
    logic [7:0] an;
    logic [3:0] dv;
    logic [2:0] idx;
    logic       blank;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  int         age = 0;
  int         m_idx = 0;
  logic [3:0] m_dv = 4'd0;

  function automatic bit suppressed(int i, logic [31:0] d, logic lz);
    if (!lz || i == 0) return 1'b0;
    for (int j = i; j < 8; j++)
      if (d[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: age counts cycles since the last index change
  always @(posedge clk) begin
    exp_t e;
    if (!rstn) begin
      age = 0; m_idx = 0; m_dv = 4'd0;
    end else begin
      m_dv = data[4*m_idx +: 4];
      if (age >= BLANK_CYC && tick) begin
        m_idx = (m_idx + 1) % 8;
        age = 0;
      end else begin
        age++;
      end
    end
    e.idx   = 3'(m_idx);
    e.dv    = m_dv;
    e.blank = (age < BLANK_CYC);
    e.an    = 8'hFF;
    if (!e.blank
        && ((age - BLANK_CYC) % 8) <= int'(bright)
        && !(blink_mask[m_idx] && blink_phase)
        && !suppressed(m_idx, data, lz_en))
      e.an[m_idx] = 1'b0;
    q.push_back(e);
    started = 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = q.pop_front();
        if (an !== e.an || digit_val !== e.dv ||
            scan_idx !== e.idx || blank !== e.blank) begin
          errors++;
          $display("FAIL outputs t=%0t got an=%h dv=%h idx=%0d blank=%b want an=%h dv=%h idx=%0d blank=%b",
                   $time, an, digit_val, scan_idx, blank,
                   e.an, e.dv, e.idx, e.blank);
        end
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL one_cold t=%0t got an=%h want at most one zero", $time, an);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic scan_slots(int slots, int gap);
    for (int s = 0; s < slots; s++) begin
      pulse_tick();
      step(gap);
    end
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    for (int i = 0; i < 8; i++)
      d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0
                    : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    rstn = 1'b0; tick = 1'b0; data = 32'h76543210;
    bright = 3'd7; blink_mask = 8'h00; blink_phase = 1'b0;
    lz_en = 1'b0;
    step(3);
    rstn = 1'b1;
    step(12);

    scan_slots(9, 19);

    bright = 3'd1;
    scan_slots(3, 39);
    bright = 3'd0;
    scan_slots(3, 39);

    bright = 3'd7; blink_mask = 8'h04; blink_phase = 1'b1;
    scan_slots(8, 12);
    blink_phase = 1'b0;
    scan_slots(8, 12);
    blink_mask = 8'h00;

    data = 32'h00000405; lz_en = 1'b1;
    scan_slots(8, 10);
    data = 32'h0;
    scan_slots(8, 10);
    lz_en = 1'b0;
    scan_slots(8, 10);
    data = 32'h76543210;

    pulse_tick();
    step(1);
    pulse_tick();
    step(8);

    for (int k = 0; k < 40 && m_idx != 5; k++) begin
      pulse_tick();
      step(8);
    end
    step(3);
    rstn = 1'b0; tick = 1'b1;
    step(1);
    rstn = 1'b1; tick = 1'b0;
    step(10);

    tick = 1'b1;
    step(50);
    tick = 1'b0;
    step(10);

    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) blink_mask = 8'($urandom);
      if ($urandom_range(0, 19) == 0) blink_phase = ~blink_phase;
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 39) == 0) data = rand_data();
      rstn = ($urandom_range(0, 499) != 0);
      step(1);
    end
    rstn = 1'b1; tick = 1'b0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller for the 8-digit multiplexed 7-segment display. It sequences the digit index from the prescaler's 1 kHz tick and inserts an anti-ghosting blank gap at every digit change. It also drives per-digit anode enables with brightness PWM, per-digit blink and leading-zero suppression. It replaces the free-running digit counter/decoder pair, and its digit_val output feeds the existing segment decoder.

Parameters:
NDIG, 8, number of digits scanned (index width 3; 8 is the only supported value)
BLANK_CYC, 4, clk cycles all anodes stay off after each digit change (1..15)
PWM_W, 3, width of brightness PWM counter and bright input

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active-low
tick  in  1  single-cycle scan-advance strobe (eo_1K from prescaler)
data  in  32  packed BCD digits; digit i = data[4i+3:4i]
bright  in  PWM_W  brightness; 0 = 1/8 duty, 7 = full on
blink_mask  in  8  bit i set = digit i blinks
blink_phase  in  1  level; when 1, digits in blink_mask are dark
lz_en  in  1  leading-zero suppression enable
an  out  8  anode enables, active-low, one-cold or all-ones
digit_val  out  4  BCD value of current digit (registered)
scan_idx  out  3  current digit index
blank  out  1  1 while in BLANK state

Behaviour:
- Reset: on clk edge with rstn=0, all state is cleared:
  - an=8'hFF, digit_val=0, scan_idx=0, blank=1.
  - FSM=BLANK, blank counter=BLANK_CYC-1, pwm counter=0.
- FSM has 2 states: BLANK and ON.
- BLANK:
  - an=8'hFF, blank=1; counter decrements each clk.
  - At counter==0 the FSM goes to ON on the next edge.
  - A tick seen during BLANK is dropped and does not advance the index.
  - BLANK lasts exactly BLANK_CYC cycles.
- ON:
  - blank=0; the pwm counter increments every clk and wraps at 2^PWM_W.
  - On tick:
    - scan_idx <= scan_idx+1, wrapping 7->0.
    - pwm counter <= 0.
    - Blank counter <= BLANK_CYC-1; FSM -> BLANK.
    - an=8'hFF from the next cycle.
- digit_val is registered every clk from data[4*scan_idx +: 4], so it lags index/data by 1 cycle. It is valid before BLANK ends because BLANK_CYC>=1.
- Anode registered in ON:
  - an[scan_idx] <= 0 iff pwm_cnt <= bright AND NOT (blink_mask[scan_idx] & blink_phase) AND NOT suppressed(scan_idx).
  - All other bits are 1.
  - an changes take effect 1 cycle after their inputs.
- suppressed(i) = lz_en & (i != 0) & (every digit j with i <= j <= 7 equals 0).
  - Digit 0 is never suppressed.
  - Non-BCD values (10..15) count as non-zero.
- The index sequence is always 0,1,...,7,0; no skipping for suppressed or blinking digits (they are dark for their slot).
- If rstn=0 mid-scan, the next edge returns to the reset values regardless of state, and tick is ignored in that cycle.
- tick held high continuously: the index advances once per BLANK+1 cycles, and there are never two active anodes.
- Invariant: an is never more than one-cold.

Test Plan:
- Reset/startup: rstn=0 for 3 clk, then release with data=32'h76543210, bright=7, no tick.
  - Required: an=FF for BLANK_CYC cycles, then an=FE steady, digit_val=0, scan_idx=0.
- Scan order: tick every 20 clk, bright=7.
  - Required: scan_idx goes 0..7,0.
  - an=FF for exactly 4 cycles after each tick, then ~(1<<idx).
  - digit_val equals idx (data 76543210).
- Brightness: bright=1, single digit held in ON for 32 clk.
  - Required: an[idx]=0 for 2 of every 8 cycles (pwm 0,1), measured over 4 PWM periods.
  - bright=0 gives 1 of 8.
- Blink: blink_mask=8'h04, blink_phase toggled.
  - Required: with phase=1, an stays FF during slot 2 while the other slots light normally.
  - With phase=0, slot 2 is lit.
- Leading zeros: data=32'h00000405, lz_en=1.
  - Required: slots 3..7 dark, slots 0,1,2 lit (digit 1 is zero but inner).
  - data=0 leaves only slot 0 lit.
  - lz_en=0 lights all slots.
- Edge cases:
  - tick during BLANK is ignored (scan_idx unchanged).
  - rstn=0 while in ON at idx=5 returns scan_idx=0, an=FF on the next edge.
  - tick held high gives an advance every BLANK_CYC+1 cycles.
